// File: rtl/mic_pkg.sv
// mic_pkg: shared tap type, fill state and offset-binary conversion for ADC consumers
package mic_pkg;
    localparam int TAP_WIDTH = 36;
    localparam int RAW_BITS = 12;
    typedef logic signed [TAP_WIDTH-1:0] tap_t;
    typedef enum logic {FILL, RUN} tap_state_e;
    function automatic tap_t adc_to_signed(input logic [RAW_BITS-1:0] raw);
        return {{(TAP_WIDTH-RAW_BITS+1){~raw[RAW_BITS-1]}}, raw[RAW_BITS-2:0]};
    endfunction
endpackage

// File: rtl/mic_decim.sv
// mic_decim: keeps one of every DECIM valid samples, restartable by clear
module mic_decim #(
    parameter int DECIM = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic valid,
    output logic accept
);
    localparam int CW = DECIM > 1 ? $clog2(DECIM) : 1;
    logic [CW-1:0] dcnt;
    logic last;
    assign last = dcnt == CW'(DECIM-1);
    assign accept = valid && !clear && last;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) dcnt <= '0;
        else if (clear) dcnt <= '0;
        else if (valid) dcnt <= last ? '0 : dcnt + 1'b1;
endmodule

// File: rtl/mic_tap_line.sv
// mic_tap_line: channel-selected, decimated, signed TAPS-deep sample window with fill tracking
module mic_tap_line import mic_pkg::*; #(
    parameter int WIDTH = 36,
    parameter int TAPS = 16,
    parameter int ADC_BITS = 12,
    parameter int NCH = 8,
    parameter int DECIM = 1,
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1,
    localparam int FW = $clog2(TAPS+1)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [0:NCH-1][ADC_BITS-1:0] adc_ch,
    input  logic                        sample_valid,
    input  logic [CW-1:0]               ch_sel,
    input  logic                        flush,
    output logic signed [WIDTH-1:0]     f [0:TAPS-1],
    output logic                        f_strobe,
    output logic                        f_valid,
    output logic [FW-1:0]               fill_count
);
    logic [CW-1:0] active;
    tap_state_e state;
    logic [ADC_BITS-1:0] raw;
    logic signed [WIDTH-1:0] s;
    logic over, clear, accept;
    assign raw = adc_ch[active];
    // offset binary to two's complement is an MSB flip, then sign-extend
    assign s = {{(WIDTH-ADC_BITS+1){~raw[ADC_BITS-1]}}, raw[ADC_BITS-2:0]};
    assign over = 32'(ch_sel) >= NCH;
    assign clear = flush || over || ch_sel != active;
    assign f_valid = state == RUN;
    mic_decim #(.DECIM(DECIM)) u_decim (
        .clock(clock), .reset_n(reset_n), .clear(clear),
        .valid(sample_valid), .accept(accept)
    );
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            for (int i = 0; i < TAPS; i++) f[i] <= '0;
            f_strobe <= 1'b0;
            fill_count <= '0;
            state <= FILL;
            active <= '0;
        end else if (clear) begin
            for (int i = 0; i < TAPS; i++) f[i] <= '0;
            f_strobe <= 1'b0;
            fill_count <= '0;
            state <= FILL;
            active <= over ? CW'(NCH-1) : ch_sel;
        end else begin
            f_strobe <= accept;
            if (accept) begin
                f[0] <= s;
                for (int i = 1; i < TAPS; i++) f[i] <= f[i-1];
                if (state == FILL) begin
                    fill_count <= fill_count + 1'b1;
                    if (fill_count == FW'(TAPS-1)) state <= RUN;
                end
            end
        end
endmodule

// File: doc/mic_tap_line.md
Name: mic_tap_line

Overview:
- Parametrised successor to the single-channel microphone delay line.
- Takes the multi-channel ADC sample bus and a sample-valid strobe.
- Selects one channel, converts offset-binary samples to signed two's complement, optionally decimates, and shifts accepted samples into a TAPS-deep window that feeds the FIR/filter stages.
- Adds window-fill tracking, a per-update strobe, a flush, and auto-flush on channel change.

Parameters:
- WIDTH, 36, bit width of each signed tap output.
- TAPS, 16, delay-line depth (≥2).
- ADC_BITS, 12, raw ADC sample width (< WIDTH).
- NCH, 8, number of ADC channels on adc_ch.
- DECIM, 1, keep 1 of every DECIM valid samples (≥1).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- adc_ch  in  [0:NCH-1][ADC_BITS-1:0]  raw offset-binary samples, all channels.
- sample_valid  in  1  adc_ch holds a new conversion this cycle.
- ch_sel  in  $clog2(NCH)  requested channel index.
- flush  in  1  synchronous clear of window and counters.
- f  out  [0:TAPS-1] signed WIDTH  tap window; f[0] newest, f[TAPS-1] oldest.
- f_strobe  out  1  one-cycle pulse: f updated this cycle.
- f_valid  out  1  window completely filled since last clear.
- fill_count  out  $clog2(TAPS+1)  number of valid taps, saturates at TAPS.

Behaviour:
- Reset (reset_n=0, async): all f taps=0, f_strobe=0, f_valid=0, fill_count=0, decim counter=0, active channel register=0, state=FILL.
- Conversion: s = {1'b0,raw} − 2^(ADC_BITS−1), sign-extended to WIDTH. Raw 0 → −2048; 2048 → 0; 4095 → +2047 for ADC_BITS=12.
- Decimation: counter dcnt in 0..DECIM−1, advanced on each sample_valid. A sample is accepted when dcnt==DECIM−1; dcnt then wraps to 0. With DECIM=1, every valid sample is accepted.
- Accept (registered; visible the cycle after sample_valid):
  - f[0]<=s(adc_ch[active]).
  - f[i]<=f[i−1] for i=1..TAPS−1.
  - f_strobe=1 for exactly that one cycle.
- Latency: sample_valid at edge N → new f[0] and f_strobe high after edge N+1. A sample reaches f[k] after k further accepts.
- States:
  - FILL: fill_count<TAPS. Each accept increments fill_count. On the accept that makes fill_count=TAPS, go to RUN.
  - RUN: fill_count=TAPS, f_valid=1. Accepts shift without changing fill_count.
- Clear condition = flush=1, or ch_sel≠active channel register. On clear (next edge):
  - taps=0, fill_count=0, dcnt=0, f_valid=0, f_strobe=0, state=FILL.
  - active register<=ch_sel.
  - Any sample_valid in the same cycle is discarded.
- Priority: reset > clear > accept.
- A ch_sel value ≥ NCH is treated as a clear, and the active register saturates to NCH−1.
- Back-to-back sample_valid every cycle must be sustained: one accept per cycle when DECIM=1.
- No output is combinationally dependent on inputs; all outputs come from registers.

Decomposition:
- Shared package mic_pkg holds:
  - typedef tap_t: logic signed [WIDTH−1:0], parametrised via localparam defaults.
  - enum tap_state_e {FILL, RUN}.
  - function adc_to_signed(raw), for reuse by other ADC consumers.
- One natural sub-module: mic_decim, the DECIM counter producing an accept pulse with a clear input. Everything else stays in mic_tap_line.

Test Plan:
- Reset then 16 valid samples raw=0x800+k (k=1..16), DECIM=1, ch_sel=0:
  - f_strobe pulses 16 times.
  - fill_count 1..16.
  - f_valid rises with the 16th update.
  - f[0]=16, f[15]=1.
- Conversion extremes: raw 0x000, 0x800, 0xFFF on channel 3 → f[0] = −2048, 0, +2047, each sign-extended to 36 bits.
- DECIM=4, 12 consecutive valid samples with values 1..12 → exactly 3 f_strobe pulses; f[0..2]=s(12), s(8), s(4).
- After RUN is reached, flush asserted together with sample_valid:
  - next cycle all taps=0, fill_count=0, f_valid=0, no f_strobe.
  - the following valid sample lands in f[0].
- ch_sel changes 0→5 mid-fill at fill_count=7 → clear occurs; subsequent samples come from adc_ch[5]; fill restarts from 1.
- reset_n pulled low asynchronously mid-RUN, between clock edges → all outputs 0 immediately, without waiting for a clock edge. After release, normal filling resumes.
